// File: rtl/vrf_read_pkg.sv
// Shared types and constants for the VRF read-group sequencer and its credit counter.
package vrf_read_pkg;

  localparam int VRF_READ_QUEUE_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [4:0] vs;
    logic [4:0] offset;
    logic [3:0] group_index;
    logic [3:0] read_source;
    logic [2:0] instruction_index;
  } vrf_read_req_t;

  // Treating {vs, offset} as one 10-bit position makes the offset carry into vs for free.
  function automatic logic [9:0] nextPosition(input logic [4:0] vs, input logic [4:0] offset);
    return {vs, offset} + 10'd1;
  endfunction

endpackage

// File: rtl/vrf_read_credit_counter.sv
// Up/down counter of read requests in flight; full when no further request may be issued.
module vrf_read_credit_counter
  import vrf_read_pkg::*;
#(
  parameter int MAX_OUTSTANDING = VRF_READ_QUEUE_DEPTH,
  parameter int CNT_W           = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full
);

  logic [CNT_W-1:0] r_count;

  // Simultaneous inc and dec cancel; the guards keep the count inside 0..MAX_OUTSTANDING.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_count <= r_count + 1'b1;
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_full = (r_count == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/vrf_read_group_sequencer.sv
// Expands one group read command into consecutive VRF read requests and forwards the
// returned words, tagging the final one and pulsing done once the command completes.
module vrf_read_group_sequencer
  import vrf_read_pkg::*;
#(
  parameter int MAX_OUTSTANDING = VRF_READ_QUEUE_DEPTH,
  parameter int CNT_W           = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_vs,
  input  logic [4:0]  cmd_offset,
  input  logic [4:0]  cmd_len,
  input  logic [3:0]  cmd_group_index,
  input  logic [3:0]  cmd_read_source,
  input  logic [2:0]  cmd_instruction_index,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [4:0]  req_vs,
  output logic [4:0]  req_offset,
  output logic [3:0]  req_group_index,
  output logic [3:0]  req_read_source,
  output logic [2:0]  req_instruction_index,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data_bits,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_bits,
  output logic        result_last,
  output logic        done
);

  seq_state_e    r_state;
  seq_state_e    w_nextState;
  vrf_read_req_t r_req;
  logic [4:0]    r_len;
  logic [5:0]    r_issued;
  logic [5:0]    r_returned;
  logic          r_done;
  logic          w_full;
  logic          w_cmdFire;
  logic          w_reqFire;
  logic          w_dataFire;
  logic          w_lastFire;

  assign w_cmdFire  = cmd_valid && cmd_ready;
  assign w_reqFire  = req_valid && req_ready;
  assign w_dataFire = data_valid && data_ready;
  assign w_lastFire = w_dataFire && result_last;

  vrf_read_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_credit (
    .clock (clock),
    .reset (reset),
    .i_inc (w_reqFire),
    .i_dec (w_dataFire),
    .o_full(w_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Completion is only ever seen in DRAIN: the last word cannot return before its request issues.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (cmd_valid) w_nextState = ISSUE;
      end
      ISSUE: begin
        if (w_reqFire && (r_issued == {1'b0, r_len})) w_nextState = DRAIN;
      end
      DRAIN: begin
        if (w_lastFire) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // req_valid depends only on state and credits, never on req_ready.
  always_comb begin
    cmd_ready    = 1'b0;
    req_valid    = 1'b0;
    data_ready   = 1'b0;
    result_valid = 1'b0;
    result_last  = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
      end
      ISSUE: begin
        req_valid    = !w_full;
        data_ready   = result_ready;
        result_valid = data_valid;
        result_last  = (r_returned == {1'b0, r_len});
      end
      DRAIN: begin
        data_ready   = result_ready;
        result_valid = data_valid;
        result_last  = (r_returned == {1'b0, r_len});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_req      <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_lastFire;
      if (w_cmdFire) begin
        r_req.vs                <= cmd_vs;
        r_req.offset            <= cmd_offset;
        r_req.group_index       <= cmd_group_index;
        r_req.read_source       <= cmd_read_source;
        r_req.instruction_index <= cmd_instruction_index;
        r_len                   <= cmd_len;
        r_issued                <= '0;
        r_returned              <= '0;
      end else begin
        if (w_reqFire) begin
          {r_req.vs, r_req.offset} <= nextPosition(r_req.vs, r_req.offset);
          r_issued                 <= r_issued + 6'd1;
        end
        if (w_dataFire) begin
          r_returned <= r_returned + 6'd1;
        end
      end
    end
  end

  assign req_vs                = r_req.vs;
  assign req_offset            = r_req.offset;
  assign req_group_index       = r_req.group_index;
  assign req_read_source       = r_req.read_source;
  assign req_instruction_index = r_req.instruction_index;
  assign result_bits           = data_bits;
  assign done                  = r_done;

endmodule

// File: tb/tb_vrf_read_group_sequencer.sv
// Bench for vrf_read_group_sequencer: behavioural read-pipe model, request/result scoreboards,
// a command table run under random stalls, and hand-written credit/backpressure/reset sequences.
module tb_vrf_read_group_sequencer;

  typedef struct {
    logic [4:0] vs;
    logic [4:0] off;
    logic [4:0] len;
    logic [3:0] gi;
    logic [3:0] rs;
    logic [2:0] ii;
    logic [4:0] expLastVs;
    logic [4:0] expLastOff;
  } cmdVec_t;

  typedef struct {
    logic [4:0] vs;
    logic [4:0] off;
    logic [3:0] gi;
    logic [3:0] rs;
    logic [2:0] ii;
    bit         last;
  } expReq_t;

  typedef struct {
    logic [31:0] bits;
    bit          last;
  } expRes_t;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_vs;
  logic [4:0]  cmd_offset;
  logic [4:0]  cmd_len;
  logic [3:0]  cmd_group_index;
  logic [3:0]  cmd_read_source;
  logic [2:0]  cmd_instruction_index;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_vs;
  logic [4:0]  req_offset;
  logic [3:0]  req_group_index;
  logic [3:0]  req_read_source;
  logic [2:0]  req_instruction_index;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_bits;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_bits;
  logic        result_last;
  logic        done;

  int          compared = 0;
  int          mismatched = 0;
  expReq_t     reqQ[$];
  expRes_t     resQ[$];
  logic [31:0] pipeQ[$];
  logic [31:0] nextWord = 32'h1000_0001;
  bit          pipeEn = 0;
  bit          randMode = 0;
  bit          mActive = 0;
  bit          mDoneExp = 0;
  int          mIssued = 0;
  int          mOut = 0;
  int          mLen = 0;
  bit          cmdSeen = 0;
  int          reqFireCount = 0;
  int          doneCount = 0;
  logic [4:0]  lastVs = '0;
  logic [4:0]  lastOff = '0;
  logic [31:0] lastBits = '0;

  vrf_read_group_sequencer dut (
    .clock                (clock),
    .reset                (reset),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_vs               (cmd_vs),
    .cmd_offset           (cmd_offset),
    .cmd_len              (cmd_len),
    .cmd_group_index      (cmd_group_index),
    .cmd_read_source      (cmd_read_source),
    .cmd_instruction_index(cmd_instruction_index),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_vs               (req_vs),
    .req_offset           (req_offset),
    .req_group_index      (req_group_index),
    .req_read_source      (req_read_source),
    .req_instruction_index(req_instruction_index),
    .data_valid           (data_valid),
    .data_ready           (data_ready),
    .data_bits            (data_bits),
    .result_valid         (result_valid),
    .result_ready         (result_ready),
    .result_bits          (result_bits),
    .result_last          (result_last),
    .done                 (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drivePipe();
    data_valid = pipeEn && (pipeQ.size() > 0);
    data_bits  = (pipeQ.size() > 0) ? pipeQ[0] : 32'h0;
  endtask

  // One clock: check at negedge against the model, then advance the model at posedge.
  task automatic applyStimulus();
    bit      cf, rf, df, lastDf;
    expReq_t er;
    expRes_t es;
    logic [9:0] pos;
    lastDf = 0;
    @(negedge clock);
    cf = !reset && cmd_valid && !mActive;
    rf = !reset && req_valid && req_ready;
    df = !reset && data_valid && data_ready;
    if (!reset) begin
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(!mActive));
      checkOutput("req_valid", 32'(req_valid), 32'(mActive && (mIssued <= mLen) && (mOut < 4)));
      checkOutput("data_ready", 32'(data_ready), 32'(mActive && result_ready));
      checkOutput("result_valid", 32'(result_valid), 32'(mActive && data_valid));
      checkOutput("done", 32'(done), 32'(mDoneExp));
      if (done) doneCount++;
      if (rf) begin
        if (reqQ.size() == 0) begin
          checkOutput("req_unexpected", 32'd1, 32'd0);
        end else begin
          er = reqQ.pop_front();
          checkOutput("req_vs", 32'(req_vs), 32'(er.vs));
          checkOutput("req_offset", 32'(req_offset), 32'(er.off));
          checkOutput("req_group_index", 32'(req_group_index), 32'(er.gi));
          checkOutput("req_read_source", 32'(req_read_source), 32'(er.rs));
          checkOutput("req_instruction_index", 32'(req_instruction_index), 32'(er.ii));
          if (er.last) begin
            lastVs  = req_vs;
            lastOff = req_offset;
          end
          es.last = er.last;
        end
      end
      if (df) begin
        if (resQ.size() == 0) begin
          checkOutput("result_unexpected", 32'd1, 32'd0);
        end else begin
          expRes_t ex;
          ex = resQ.pop_front();
          checkOutput("result_bits", result_bits, ex.bits);
          checkOutput("result_last", 32'(result_last), 32'(ex.last));
          lastDf = ex.last;
          if (ex.last) lastBits = result_bits;
        end
      end
    end
    @(posedge clock);
    if (reset) begin
      mActive = 0; mDoneExp = 0; mIssued = 0; mOut = 0;
      reqQ.delete(); resQ.delete(); pipeQ.delete();
    end else begin
      mDoneExp = lastDf;
      if (df) begin
        void'(pipeQ.pop_front());
        mOut--;
        if (lastDf) mActive = 0;
      end
      if (rf) begin
        mIssued++;
        mOut++;
        reqFireCount++;
        pipeQ.push_back(nextWord);
        es.bits = nextWord;
        resQ.push_back(es);
        nextWord = nextWord + 32'h0101_0101;
      end
      if (cf) begin
        mActive = 1; mIssued = 0; mOut = 0; mLen = int'(cmd_len);
        cmdSeen = 1;
        pos = {cmd_vs, cmd_offset};
        for (int i = 0; i <= int'(cmd_len); i++) begin
          er.vs = pos[9:5]; er.off = pos[4:0];
          er.gi = cmd_group_index; er.rs = cmd_read_source; er.ii = cmd_instruction_index;
          er.last = (i == int'(cmd_len));
          reqQ.push_back(er);
          pos = pos + 10'd1;
        end
      end
    end
    #1;
    if (randMode) begin
      req_ready    = ($urandom_range(0, 3) != 0);
      result_ready = ($urandom_range(0, 3) != 0);
      pipeEn       = ($urandom_range(0, 2) != 0);
    end
    drivePipe();
  endtask

  task automatic startCmd(input logic [4:0] vs, input logic [4:0] off, input logic [4:0] len,
                          input logic [3:0] gi, input logic [3:0] rs, input logic [2:0] ii);
    cmd_vs = vs; cmd_offset = off; cmd_len = len;
    cmd_group_index = gi; cmd_read_source = rs; cmd_instruction_index = ii;
    cmd_valid = 1'b1;
    cmdSeen = 0;
    for (int i = 0; i < 20 && !cmdSeen; i++) applyStimulus();
    if (!cmdSeen) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (mActive && n < budget) begin
      applyStimulus();
      n++;
    end
    if (mActive) checkOutput("idle_timeout", 32'd0, 32'd1);
    applyStimulus();
    checkOutput("req_scoreboard_empty", 32'(reqQ.size()), 32'd0);
    checkOutput("res_scoreboard_empty", 32'(resQ.size()), 32'd0);
  endtask

  cmdVec_t vecs[6];
  int      base;
  int      doneBase;

  initial begin
    vecs[0] = '{vs: 5'd5,  off: 5'd30, len: 5'd3,  gi: 4'd1, rs: 4'd2, ii: 3'd3, expLastVs: 5'd6,  expLastOff: 5'd1};
    vecs[1] = '{vs: 5'd31, off: 5'd31, len: 5'd1,  gi: 4'd9, rs: 4'd4, ii: 3'd5, expLastVs: 5'd0,  expLastOff: 5'd0};
    vecs[2] = '{vs: 5'd0,  off: 5'd0,  len: 5'd31, gi: 4'd7, rs: 4'd8, ii: 3'd1, expLastVs: 5'd0,  expLastOff: 5'd31};
    vecs[3] = '{vs: 5'd10, off: 5'd20, len: 5'd15, gi: 4'd3, rs: 4'd15, ii: 3'd7, expLastVs: 5'd11, expLastOff: 5'd3};
    vecs[4] = '{vs: 5'd2,  off: 5'd31, len: 5'd0,  gi: 4'd15, rs: 4'd0, ii: 3'd2, expLastVs: 5'd2,  expLastOff: 5'd31};
    vecs[5] = '{vs: 5'd31, off: 5'd16, len: 5'd31, gi: 4'd5, rs: 4'd6, ii: 3'd4, expLastVs: 5'd0,  expLastOff: 5'd15};

    reset = 1'b1; cmd_valid = 1'b0; cmd_vs = '0; cmd_offset = '0; cmd_len = '0;
    cmd_group_index = '0; cmd_read_source = '0; cmd_instruction_index = '0;
    req_ready = 1'b0; result_ready = 1'b0; data_valid = 1'b0; data_bits = '0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_req_valid", 32'(req_valid), 32'd0);
    checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_req_fields", {12'd0, req_vs, req_offset, req_group_index, req_read_source, req_instruction_index}, 32'd0);

    // Single element with a known data word
    req_ready = 1'b1; result_ready = 1'b1; pipeEn = 1'b1; nextWord = 32'hDEAD_BEEF;
    doneBase = doneCount;
    startCmd(5'd3, 5'd7, 5'd0, 4'd2, 4'd3, 3'd4);
    waitIdle(50);
    checkOutput("single_last_vs", 32'(lastVs), 32'd3);
    checkOutput("single_last_off", 32'(lastOff), 32'd7);
    checkOutput("single_data", lastBits, 32'hDEAD_BEEF);
    checkOutput("single_done_count", 32'(doneCount - doneBase), 32'd1);

    // Table of commands under random handshake stalls
    for (int v = 0; v < 6; v++) begin
      randMode = 1'b1;
      doneBase = doneCount;
      startCmd(vecs[v].vs, vecs[v].off, vecs[v].len, vecs[v].gi, vecs[v].rs, vecs[v].ii);
      waitIdle(2000);
      checkOutput("table_last_vs", 32'(lastVs), 32'(vecs[v].expLastVs));
      checkOutput("table_last_off", 32'(lastOff), 32'(vecs[v].expLastOff));
      checkOutput("table_done_count", 32'(doneCount - doneBase), 32'd1);
    end
    randMode = 1'b0;

    // Credit stall: four requests, then one more per returned word
    req_ready = 1'b1; result_ready = 1'b1; pipeEn = 1'b0; drivePipe();
    base = reqFireCount;
    startCmd(5'd1, 5'd4, 5'd9, 4'd6, 4'd1, 3'd0);
    repeat (8) applyStimulus();
    checkOutput("stall_reqs", 32'(reqFireCount - base), 32'd4);
    pipeEn = 1'b1; drivePipe();
    applyStimulus();
    pipeEn = 1'b0; drivePipe();
    repeat (6) applyStimulus();
    checkOutput("stall_release_reqs", 32'(reqFireCount - base), 32'd5);
    pipeEn = 1'b1; drivePipe();
    waitIdle(200);

    // Result backpressure with a competing command offered
    req_ready = 1'b1; result_ready = 1'b0; pipeEn = 1'b1; drivePipe();
    base = reqFireCount;
    startCmd(5'd4, 5'd2, 5'd5, 4'd8, 4'd9, 3'd6);
    cmd_vs = 5'd17; cmd_offset = 5'd17; cmd_len = 5'd2; cmd_valid = 1'b1;
    repeat (8) applyStimulus();
    checkOutput("backpressure_reqs", 32'(reqFireCount - base), 32'd4);
    cmd_valid = 1'b0;
    result_ready = 1'b1;
    waitIdle(200);
    checkOutput("backpressure_last_off", 32'(lastOff), 32'd7);

    // Reset in the middle of ISSUE, then a fresh command
    req_ready = 1'b1; result_ready = 1'b1; pipeEn = 1'b0; drivePipe();
    base = reqFireCount;
    startCmd(5'd8, 5'd20, 5'd7, 4'd4, 4'd4, 3'd4);
    applyStimulus();
    applyStimulus();
    checkOutput("pre_reset_reqs", 32'(reqFireCount - base), 32'd2);
    req_ready = 1'b0;
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("post_reset_req_valid", 32'(req_valid), 32'd0);
    checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("post_reset_req_offset", 32'(req_offset), 32'd0);
    req_ready = 1'b1; pipeEn = 1'b1; drivePipe();
    startCmd(5'd9, 5'd12, 5'd2, 4'd1, 4'd1, 3'd1);
    waitIdle(100);
    checkOutput("restart_last_vs", 32'(lastVs), 32'd9);
    checkOutput("restart_last_off", 32'(lastOff), 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vrf_read_group_sequencer.md
Name: vrf_read_group_sequencer

Overview:
- Sits directly upstream of the VRF read pipe and feeds its enqueue request port.
- Takes one read command per instruction group and expands it into a run of per-element VRF read requests with consecutive offsets.
- Limits reads in flight to the read pipe's data-queue depth using a credit counter.
- Consumes the returned data words and passes them on, tagging the final word with last and pulsing done when the command completes.

Parameters:
- MAX_OUTSTANDING, 4, maximum requests issued but not yet returned as data; must be ≤ read pipe data-queue depth.
- CNT_W, 3, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUTSTANDING.

Ports:
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted; high only in IDLE.
- cmd_vs  in  5  starting vector register.
- cmd_offset  in  5  starting offset within the register.
- cmd_len  in  5  number of elements minus 1 (1..32 elements).
- cmd_group_index  in  4  group index copied to every request.
- cmd_read_source  in  4  read source copied to every request.
- cmd_instruction_index  in  3  instruction index copied to every request.
- req_valid  out  1  read request to the read pipe enqueue port.
- req_ready  in  1  read pipe enqueue ready.
- req_vs  out  5  current register.
- req_offset  out  5  current offset.
- req_group_index  out  4  registered copy of cmd_group_index.
- req_read_source  out  4  registered copy of cmd_read_source.
- req_instruction_index  out  3  registered copy of cmd_instruction_index.
- data_valid  in  1  read pipe dequeue valid.
- data_ready  out  1  read pipe dequeue ready.
- data_bits  in  32  read pipe dequeue data.
- result_valid  out  1  returned word to consumer.
- result_ready  in  1  consumer ready.
- result_bits  out  32  equals data_bits, combinational.
- result_last  out  1  marks the final word of the command.
- done  out  1  one-cycle pulse after the final word transfers.

Behaviour:
- States: IDLE, ISSUE, DRAIN.
- Reset values: state=IDLE, cmd_ready=1, req_valid=0, result_valid=0, done=0, outstanding=0, issued=0, returned=0; all request fields 0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch all command fields and clear issued/returned counters (6-bit), then go to ISSUE next cycle.
- ISSUE:
  - req_valid = (outstanding < MAX_OUTSTANDING). No combinational path from req_ready to req_valid.
  - On req fire (req_valid & req_ready):
    - issued++.
    - offset++ (5-bit). When offset wraps 31→0, vs++ (5-bit; vs 31 wraps to 0 silently).
  - When the request fire makes issued == len+1, go to DRAIN.
- ISSUE and DRAIN, data side:
  - data_ready = result_ready; result_valid = data_valid (pure pass-through).
  - A data fire decrements outstanding and increments returned.
  - result_last = (returned == len).
- Outstanding counter:
  - Request fire alone: +1. Data fire alone: −1.
  - Request fire and data fire in the same cycle: value unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Transfer of the last word: return to IDLE next cycle and assert done for exactly one cycle. This can happen while still in ISSUE only if len+1 ≤ words already returned, which is impossible, so it always occurs in DRAIN.
- IDLE, data side: data_ready=0 and result_valid=0; stray data is held off, never dropped.
- Request latency: first req_valid in the cycle after cmd fire; back-to-back issue at one per cycle while credits remain.
- Reset mid-operation: immediate return to IDLE with all counters cleared. Data already in flight in the read pipe is the owner's responsibility; that pipe is reset together with this block.

Decomposition:
- Shared package vrf_read_pkg holds:
  - typedef vrf_read_req_t {vs[4:0], offset[4:0], group_index[3:0], read_source[3:0], instruction_index[2:0]};
  - typedef for state enum seq_state_e {IDLE, ISSUE, DRAIN};
  - constant VRF_READ_QUEUE_DEPTH=4, used as the MAX_OUTSTANDING default.
- One natural sub-module: vrf_read_credit_counter (up/down counter with simultaneous inc/dec, full flag at MAX_OUTSTANDING).

Test Plan:
- Single element: cmd vs=3, offset=7, len=0, req_ready=1 → one request vs=3/offset=7; data 0xDEADBEEF returned → result_last=1, done pulses one cycle later, cmd_ready=1.
- Offset wrap: vs=5, offset=30, len=3 → requests (5,30), (5,31), (6,0), (6,1); vs=31, offset=31, len=1 → (31,31), (0,0).
- Credit stall: len=9, req_ready=1, data_valid held 0 → exactly 4 requests, then req_valid=0; release one data word → exactly one more request.
- Simultaneous issue and return at outstanding=4−1: counter holds at 3; across len=31 with random stalls, 32 requests and 32 results, last only on the 32nd.
- Backpressure: result_ready=0 → data_ready=0, outstanding frozen; cmd_valid asserted during ISSUE/DRAIN is not accepted.
- Reset mid-ISSUE after 2 requests → next cycle state IDLE, req_valid=0, cmd_ready=1, new command restarts from its own offset.
